// File: rtl/configurable_uart_pkg.sv
// Shared definitions for the configurable UART: parity modes, FSM state
// encodings and the three-sample majority vote used by the receiver.
package configurable_uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  // Two out of three samples decide the bit value.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/configurable_uart_tick.sv
// Oversample tick generator: one-cycle pulse every DIV clock cycles,
// shared by the receiver and the transmitter.
module configurable_uart_tick #(
  parameter int DIV = 2
) (
  input  logic clock,
  input  logic arst,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Free-running divider; the tick fires when the count wraps.
  always_comb begin
    tick_d = 1'b0;
    cnt_d  = cnt_q + CNT_ONE;
    if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  // Divider state.
  always_ff @(posedge clock or posedge arst) begin
    if (arst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/configurable_uart.sv
// Configurable UART: oversampling receiver with majority vote, parity and
// break detection, plus a transmitter with back-to-back write support.
module configurable_uart
  import configurable_uart_pkg::*;
#(
  parameter int SYSTEM_FREQ = 50_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16
) (
  input  logic                 clock,
  input  logic                 arst,
  input  logic                 rx_bit,
  output logic                 tx_bit,
  output logic [DATA_BITS-1:0] rx_value,
  output logic                 rx_value_ready,
  output logic                 rx_frame_error,
  output logic                 rx_parity_error,
  output logic                 rx_break,
  input  logic [DATA_BITS-1:0] tx_value,
  input  logic                 tx_value_write,
  output logic                 tx_value_ready,
  output logic                 tx_value_done
);

  localparam int DIV = SYSTEM_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int SCW = $clog2(OVERSAMPLE);
  localparam logic [SCW-1:0] S_ONE  = SCW'(1);
  localparam logic [SCW-1:0] S_V0   = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] S_V1   = SCW'(OVERSAMPLE / 2);
  localparam logic [SCW-1:0] S_V2   = SCW'(OVERSAMPLE / 2 + 1);
  localparam logic [SCW-1:0] S_LAST = SCW'(OVERSAMPLE - 1);
  localparam logic [3:0]     D_LAST = 4'(DATA_BITS - 1);
  localparam logic [1:0]     PAR_MODE  = 2'(PARITY);
  localparam logic           STOP_LAST = 1'(STOP_BITS - 1);

  generate
    if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || OVERSAMPLE < 8 || OVERSAMPLE > 32 ||
        (OVERSAMPLE % 2) != 0) begin : g_param_check
      $error("configurable_uart: illegal parameter combination");
    end
  endgenerate

  logic tick;

  configurable_uart_tick #(
    .DIV (DIV)
  ) u_tick (
    .clock (clock),
    .arst  (arst),
    .tick  (tick)
  );

  // ---------------------------------------------------------------- receiver
  logic [1:0]           rx_sync_q, rx_sync_d;
  logic                 rx_prev_q, rx_prev_d;
  rx_state_t            rx_state_q, rx_state_d;
  logic [SCW-1:0]       rx_cnt_q, rx_cnt_d;
  logic [3:0]           rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_v0_q, rx_v0_d, rx_v1_q, rx_v1_d;
  logic                 rx_par_q, rx_par_d;
  logic                 rx_one_q, rx_one_d;
  logic [DATA_BITS-1:0] rx_value_q, rx_value_d;
  logic                 rx_ready_q, rx_ready_d;
  logic                 rx_fe_q, rx_fe_d, rx_pe_q, rx_pe_d, rx_brk_q, rx_brk_d;
  logic                 rx_s, vote, par_calc;

  assign rx_s = rx_sync_q[1];

  // Receive FSM: edge detect, tick counting, voting and result reporting.
  always_comb begin
    rx_sync_d  = {rx_sync_q[0], rx_bit};
    rx_prev_d  = rx_s;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_v0_d    = rx_v0_q;
    rx_v1_d    = rx_v1_q;
    rx_par_d   = rx_par_q;
    rx_one_d   = rx_one_q;
    rx_value_d = rx_value_q;
    rx_ready_d = 1'b0;
    rx_fe_d    = rx_fe_q;
    rx_pe_d    = rx_pe_q;
    rx_brk_d   = rx_brk_q;
    vote       = majority3(rx_v0_q, rx_v1_q, rx_s);
    par_calc   = (^rx_shift_q) ^ rx_par_q;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_one_d   = 1'b0;
        end
      end
      RX_WAIT_IDLE: begin
        // Any low sample restarts the one-bit-time idle qualification.
        if (!rx_s) begin
          rx_cnt_d = '0;
        end else if (tick) begin
          if (rx_cnt_q == S_LAST) begin
            rx_state_d = RX_IDLE;
            rx_cnt_d   = '0;
          end else begin
            rx_cnt_d = rx_cnt_q + S_ONE;
          end
        end
      end
      default: begin
        if (tick) begin
          rx_cnt_d = (rx_cnt_q == S_LAST) ? '0 : rx_cnt_q + S_ONE;
          if (rx_cnt_q == S_V0) rx_v0_d = rx_s;
          if (rx_cnt_q == S_V1) rx_v1_d = rx_s;
          if (rx_cnt_q == S_V2) begin
            case (rx_state_q)
              RX_START: begin
                if (vote) begin
                  rx_state_d = RX_IDLE;
                  rx_cnt_d   = '0;
                end
              end
              RX_DATA: begin
                rx_shift_d = {vote, rx_shift_q[DATA_BITS-1:1]};
                rx_one_d   = rx_one_q | vote;
              end
              RX_PARITY: begin
                rx_par_d = vote;
                rx_one_d = rx_one_q | vote;
              end
              RX_STOP: begin
                // The frame ends at the stop-bit vote; a second stop bit looks like idle.
                rx_ready_d = 1'b1;
                rx_value_d = rx_shift_q;
                rx_fe_d    = ~vote;
                rx_brk_d   = ~vote & ~rx_one_q;
                rx_pe_d    = (PAR_MODE == PAR_EVEN) ? par_calc :
                             (PAR_MODE == PAR_ODD)  ? ~par_calc : 1'b0;
                rx_state_d = (~vote & ~rx_one_q) ? RX_WAIT_IDLE : RX_IDLE;
                rx_cnt_d   = '0;
              end
              default: ;
            endcase
          end
          if (rx_cnt_q == S_LAST) begin
            case (rx_state_q)
              RX_START: rx_state_d = RX_DATA;
              RX_DATA: begin
                if (rx_idx_q == D_LAST) begin
                  rx_state_d = (PAR_MODE == PAR_NONE) ? RX_STOP : RX_PARITY;
                end else begin
                  rx_idx_d = rx_idx_q + 4'd1;
                end
              end
              RX_PARITY: rx_state_d = RX_STOP;
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  // Receiver state; the synchroniser and edge detector preset to the idle level.
  always_ff @(posedge clock or posedge arst) begin
    if (arst) begin
      rx_sync_q  <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_v0_q    <= 1'b1;
      rx_v1_q    <= 1'b1;
      rx_par_q   <= 1'b0;
      rx_one_q   <= 1'b0;
      rx_value_q <= '0;
      rx_ready_q <= 1'b0;
      rx_fe_q    <= 1'b0;
      rx_pe_q    <= 1'b0;
      rx_brk_q   <= 1'b0;
    end else begin
      rx_sync_q  <= rx_sync_d;
      rx_prev_q  <= rx_prev_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_v0_q    <= rx_v0_d;
      rx_v1_q    <= rx_v1_d;
      rx_par_q   <= rx_par_d;
      rx_one_q   <= rx_one_d;
      rx_value_q <= rx_value_d;
      rx_ready_q <= rx_ready_d;
      rx_fe_q    <= rx_fe_d;
      rx_pe_q    <= rx_pe_d;
      rx_brk_q   <= rx_brk_d;
    end
  end

  assign rx_value        = rx_value_q;
  assign rx_value_ready  = rx_ready_q;
  assign rx_frame_error  = rx_fe_q;
  assign rx_parity_error = rx_pe_q;
  assign rx_break        = rx_brk_q;

  // ------------------------------------------------------------- transmitter
  tx_state_t            tx_state_q, tx_state_d;
  logic [SCW-1:0]       tx_cnt_q, tx_cnt_d;
  logic [3:0]           tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_stop_q, tx_stop_d;
  logic                 tx_launch_q, tx_launch_d;
  logic                 tx_bit_q, tx_bit_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 tx_done_q, tx_done_d;

  // Transmit FSM: accept in idle, align the start bit to a tick, then shift out.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_idx_d    = tx_idx_q;
    tx_shift_d  = tx_shift_q;
    tx_par_d    = tx_par_q;
    tx_stop_d   = tx_stop_q;
    tx_launch_d = tx_launch_q;
    tx_bit_d    = tx_bit_q;
    tx_done_d   = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_bit_d = 1'b1;
        if (tx_ready_q && tx_value_write) begin
          tx_shift_d  = tx_value;
          tx_par_d    = (PAR_MODE == PAR_ODD) ? ~(^tx_value) : (^tx_value);
          tx_state_d  = TX_START;
          tx_launch_d = 1'b0;
          tx_cnt_d    = '0;
        end
      end
      default: begin
        if (tick) begin
          if (tx_state_q == TX_START && !tx_launch_q) begin
            tx_launch_d = 1'b1;
            tx_bit_d    = 1'b0;
            tx_cnt_d    = '0;
          end else if (tx_cnt_q != S_LAST) begin
            tx_cnt_d = tx_cnt_q + S_ONE;
          end else begin
            tx_cnt_d = '0;
            case (tx_state_q)
              TX_START: begin
                tx_state_d = TX_DATA;
                tx_idx_d   = '0;
                tx_bit_d   = tx_shift_q[0];
              end
              TX_DATA: begin
                if (tx_idx_q == D_LAST) begin
                  if (PAR_MODE != PAR_NONE) begin
                    tx_state_d = TX_PARITY;
                    tx_bit_d   = tx_par_q;
                  end else begin
                    tx_state_d = TX_STOP;
                    tx_bit_d   = 1'b1;
                    tx_stop_d  = 1'b0;
                  end
                end else begin
                  tx_idx_d   = tx_idx_q + 4'd1;
                  tx_shift_d = tx_shift_q >> 1;
                  tx_bit_d   = tx_shift_q[1];
                end
              end
              TX_PARITY: begin
                tx_state_d = TX_STOP;
                tx_bit_d   = 1'b1;
                tx_stop_d  = 1'b0;
              end
              TX_STOP: begin
                if (tx_stop_q == STOP_LAST) begin
                  tx_state_d = TX_IDLE;
                  tx_done_d  = 1'b1;
                end else begin
                  tx_stop_d = 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      end
    endcase
    tx_ready_d = (tx_state_d == TX_IDLE);
  end

  // Transmitter state; line idles high and no write is accepted during reset.
  always_ff @(posedge clock or posedge arst) begin
    if (arst) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_idx_q    <= '0;
      tx_shift_q  <= '0;
      tx_par_q    <= 1'b0;
      tx_stop_q   <= 1'b0;
      tx_launch_q <= 1'b0;
      tx_bit_q    <= 1'b1;
      tx_ready_q  <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_idx_q    <= tx_idx_d;
      tx_shift_q  <= tx_shift_d;
      tx_par_q    <= tx_par_d;
      tx_stop_q   <= tx_stop_d;
      tx_launch_q <= tx_launch_d;
      tx_bit_q    <= tx_bit_d;
      tx_ready_q  <= tx_ready_d;
      tx_done_q   <= tx_done_d;
    end
  end

  assign tx_bit         = tx_bit_q;
  assign tx_value_ready = tx_ready_q;
  assign tx_value_done  = tx_done_q;

endmodule
